rega_multizona: RTL and testbench
=================================

Name: rega_multizona

Overview:
Parametrised successor to the single-bed irrigation controller. It serves NZ irrigation zones with a round-robin scheduler driven by per-zone soil-dryness sensors. A tank-level interlock gates all watering. An optional fertilise/clean cycle runs after a zone's watering, and the block exports the active zone and the remaining-time counter for the display selector.

Parameters:
NZ, 4, number of zones (2..16)
ZW, 2, zone index width; must equal clog2(NZ)
TW, 8, width of the remaining-time counter
DUR_IRR, 10, irrigation duration in ticks (1..2^TW-1)
DUR_ADUB, 4, fertiliser-mix duration in ticks
DUR_LIMP, 3, line-cleaning duration in ticks
TICK_DIV, 4, Clk cycles per tick (≥2)

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous, active-high reset
Us  in  NZ  per-zone soil-dry request, 1 = dry
Nv  in  2  tank level; 2'b00 = empty
Adub  in  1  fertilise request pulse, single cycle, latched
Valv  out  NZ  zone valves, one-hot or zero
Mist  out  1  fertiliser mixer valve
Limp  out  1  cleaning valve
Zona  out  ZW  index of the active/last-served zone
Tempo  out  TW  remaining ticks of the current phase; 0 in IDLE
Ocupado  out  1  FSM not in IDLE
Vazio  out  1  registered (Nv==2'b00)

Behaviour:
- Interface: one clock, Clk. Rst is synchronous and active-high, sampled on the Clk rising edge, and dominates every other input.
- Reset state: all outputs 0, FSM=IDLE, round-robin pointer ptr=0, adub_pend=0, prescaler=0.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1.
  - Cleared to 0 on every entry into a timed state, so each phase lasts exactly DUR*TICK_DIV cycles.
- adub_pend: set by Adub=1 in any state except under Rst; cleared only on LIMPA completion or Rst.
- States: IDLE, IRRIGA, ADUBA, LIMPA. All outputs are registered.
- IDLE:
  - If Nv≠0 and Us≠0, select the first i in the order ptr, ptr+1, … (mod NZ) with Us[i]=1.
  - Next cycle: IRRIGA, Valv=1<<i, Zona=i, Tempo=DUR_IRR, Ocupado=1.
  - Latency is 1 cycle from a qualifying request to the valve opening.
- IRRIGA:
  - Tempo decrements on each tick.
  - On the tick where Tempo==1: set ptr=(Zona+1) mod NZ, then go to ADUBA if adub_pend else IDLE (Tempo=0, Valv=0).
  - Us[Zona] dropping mid-phase does not shorten the phase (see the optional feature).
- ADUBA:
  - Valv stays on the zone, Mist=1, Tempo=DUR_ADUB; decrements per tick.
  - At Tempo==1 on a tick: go to LIMPA.
- LIMPA:
  - Valv stays on the zone, Mist=0, Limp=1, Tempo=DUR_LIMP.
  - At Tempo==1 on a tick: clear adub_pend, go to IDLE.
- Empty tank in IRRIGA/ADUBA/LIMPA:
  - Nv==0 sampled in any of these states → next cycle IDLE, all valves 0, Tempo=0.
  - ptr is unchanged, so the same zone has priority on refill; adub_pend is kept.
- Nv==0 in IDLE: no start; Ocupado stays 0.
- Us changes while a zone is active are ignored except as described above. A new request is evaluated only in IDLE.
- Adub arriving in the same cycle as the IRRIGA exit tick is honoured: ADUBA is entered.
- Rst mid-phase: on the next edge all outputs go to 0 and the pending request is lost.
- Wrap-around: ptr increments modulo NZ. If NZ is not a power of two, a ptr value ≥ NZ is never produced.

Optional Feature:
REGA_EARLY_STOP_EN
- Defined: in IRRIGA, if Us[Zona]==0 on a tick, the phase ends at that tick, following the same exit path as Tempo==1 (ptr advance, ADUBA if pending).
- Undefined: irrigation always runs the full DUR_IRR ticks.

Test Plan:
All scenarios use default parameters.
1. Rst; then Us=4'b0100, Nv=2'b11 → Valv=4'b0100 one cycle later, held exactly 40 cycles, Tempo counts 10..1, then IDLE with ptr=3, Zona=2.
2. Us=4'b1111 held, Nv=2'b11 → zones served in order 0,1,2,3,0, each for 40 cycles with one IDLE cycle between them.
3. Zone 1 irrigating, Nv=2'b00 at tick 5 → next cycle Valv=0, Vazio=1, Ocupado=0; then Nv=2'b01 → zone 1 restarts with Tempo=10.
4. Adub pulse during zone 1 IRRIGA → Valv=4'b0010 for 40 cycles, then Mist=1 for 16 cycles, then Limp=1 for 12 cycles, then IDLE with adub_pend=0.
5. Rst asserted during ADUBA → next edge: Valv=0, Mist=0, Limp=0, Tempo=0; after release, no ADUBA occurs without a new Adub pulse.
6. With REGA_EARLY_STOP_EN defined, zone 0 active, Us[0]→0 at tick 3 → valve closes at that tick and ptr=1; without the macro the valve stays open for all 40 cycles.

Source files
------------

// File: rtl/rega_multizona.sv
// rega_multizona: round-robin irrigation controller for NZ zones.
// A tank-level interlock gates all watering. An optional fertilise/clean
// cycle (ADUBA then LIMPA) follows a zone's irrigation when requested.
// Optional build macro REGA_EARLY_STOP_EN: a zone whose soil reports wet on a
// tick ends its irrigation at that tick instead of running the full duration.
// Every output is registered. dbgState, dbgPtr and dbgAdubPend expose the
// internal FSM state, the round-robin pointer and the latched fertilise request.
module rega_multizona #(
  parameter int NZ       = 4,
  parameter int ZW       = 2,
  parameter int TW       = 8,
  parameter int DUR_IRR  = 10,
  parameter int DUR_ADUB = 4,
  parameter int DUR_LIMP = 3,
  parameter int TICK_DIV = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [NZ-1:0] Us,
  input  logic [1:0]    Nv,
  input  logic          Adub,
  output logic [NZ-1:0] Valv,
  output logic          Mist,
  output logic          Limp,
  output logic [ZW-1:0] Zona,
  output logic [TW-1:0] Tempo,
  output logic          Ocupado,
  output logic          Vazio,
  output logic [1:0]    dbgState,
  output logic [ZW-1:0] dbgPtr,
  output logic          dbgAdubPend
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [NZ-1:0] ONE_HOT0 = NZ'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, IRRIGA = 2'd1, ADUBA = 2'd2, LIMPA = 2'd3} stateT;

  stateT         state, stateN;
  logic [PW-1:0] presc;
  logic          tick;
  logic [ZW-1:0] ptr, nextPtr, sel, idxZ;
  logic          adubPend, found, lastTick, earlyStop, irrExit, limpDone;
  int            idx;
  logic [NZ-1:0] valvN;
  logic [ZW-1:0] zonaN;
  logic [TW-1:0] tempoN;
  logic          mistN, limpN, ocupadoN;

  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign lastTick = (Tempo == TW'(1));
  assign nextPtr  = (Zona == ZW'(NZ - 1)) ? '0 : Zona + 1'b1;

`ifdef REGA_EARLY_STOP_EN
  assign earlyStop = ~Us[Zona];
`else
  assign earlyStop = 1'b0;
`endif

  // Pick the first dry zone scanning from ptr upward (mod NZ); the loop runs
  // backwards so the smallest offset is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    idxZ  = '0;
    for (int k = NZ - 1; k >= 0; k--) begin
      idx  = (int'(ptr) + k) % NZ;
      idxZ = ZW'(idx);
      if (Us[idxZ]) begin
        found = 1'b1;
        sel   = idxZ;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= stateN;
  end

  // Next-state logic; an empty tank aborts any timed phase and wins over a tick exit.
  always_comb begin
    stateN   = state;
    irrExit  = 1'b0;
    limpDone = 1'b0;
    case (state)
      IDLE: if (Nv != 2'b00 && found) stateN = IRRIGA;
      IRRIGA: begin
        if (Nv == 2'b00) stateN = IDLE;
        else if (tick && (lastTick || earlyStop)) begin
          irrExit = 1'b1;
          stateN  = (adubPend || Adub) ? ADUBA : IDLE;
        end
      end
      ADUBA: begin
        if (Nv == 2'b00) stateN = IDLE;
        else if (tick && lastTick) stateN = LIMPA;
      end
      LIMPA: begin
        if (Nv == 2'b00) stateN = IDLE;
        else if (tick && lastTick) begin
          limpDone = 1'b1;
          stateN   = IDLE;
        end
      end
      default: stateN = IDLE;
    endcase
  end

  // Next output values, derived from the upcoming state; loaded into registers below.
  always_comb begin
    valvN    = Valv;
    zonaN    = Zona;
    tempoN   = Tempo;
    mistN    = (stateN == ADUBA);
    limpN    = (stateN == LIMPA);
    ocupadoN = (stateN != IDLE);
    if (stateN == IDLE) begin
      valvN  = '0;
      tempoN = '0;
    end else if (stateN != state) begin
      case (stateN)
        IRRIGA:  tempoN = TW'(DUR_IRR);
        ADUBA:   tempoN = TW'(DUR_ADUB);
        default: tempoN = TW'(DUR_LIMP);
      endcase
      if (state == IDLE) begin
        valvN = ONE_HOT0 << sel;
        zonaN = sel;
      end
    end else if (tick) begin
      tempoN = Tempo - 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Valv    <= '0;
      Mist    <= 1'b0;
      Limp    <= 1'b0;
      Zona    <= '0;
      Tempo   <= '0;
      Ocupado <= 1'b0;
      Vazio   <= 1'b0;
    end else begin
      Valv    <= valvN;
      Mist    <= mistN;
      Limp    <= limpN;
      Zona    <= zonaN;
      Tempo   <= tempoN;
      Ocupado <= ocupadoN;
      Vazio   <= (Nv == 2'b00);
    end
  end

  // Prescaler restarts on every phase entry; pointer advances on irrigation exit;
  // a new fertilise request wins over the clear at LIMPA completion.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      presc    <= '0;
      ptr      <= '0;
      adubPend <= 1'b0;
    end else begin
      if (stateN != state || state == IDLE || tick) presc <= '0;
      else                                          presc <= presc + 1'b1;
      if (irrExit) ptr <= nextPtr;
      if (Adub)          adubPend <= 1'b1;
      else if (limpDone) adubPend <= 1'b0;
    end
  end

  assign dbgState    = state;
  assign dbgPtr      = ptr;
  assign dbgAdubPend = adubPend;

endmodule

// File: tb/tb_rega_multizona.sv
// Bench for rega_multizona with default parameters. Expected output words
// {Valv, Mist, Limp, Ocupado, Vazio, Zona, Tempo} are queued per cycle from
// the phase durations and popped one per clock as the DUT produces them.
module tb_rega_multizona;
  localparam int TD = 4;
  localparam int EW = 18;

  logic       Clk, Rst, Adub, Mist, Limp, Ocupado, Vazio, dbgAdubPend;
  logic [3:0] Us, Valv;
  logic [1:0] Nv, Zona, dbgState, dbgPtr;
  logic [7:0] Tempo;
  logic [EW-1:0] obs;
  logic [EW-1:0] exp_q[$];
  int total, bad;

  rega_multizona dut (
    .Clk(Clk), .Rst(Rst), .Us(Us), .Nv(Nv), .Adub(Adub),
    .Valv(Valv), .Mist(Mist), .Limp(Limp), .Zona(Zona), .Tempo(Tempo),
    .Ocupado(Ocupado), .Vazio(Vazio),
    .dbgState(dbgState), .dbgPtr(dbgPtr), .dbgAdubPend(dbgAdubPend)
  );

  assign obs = {Valv, Mist, Limp, Ocupado, Vazio, Zona, Tempo};

  // clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // queue one phase: ncyc cycles of a phase lasting dur ticks
  task automatic pushPhase(input logic [3:0] v, input logic m, input logic l,
                           input logic [1:0] z, input int dur, input int ncyc);
    logic [7:0] t;
    for (int k = 0; k < ncyc; k++) begin
      t = 8'(dur - k / TD);
      exp_q.push_back({v, m, l, 1'b1, 1'b0, z, t});
    end
  endtask

  task automatic pushIdle(input logic [1:0] z, input logic vz);
    exp_q.push_back({4'b0, 1'b0, 1'b0, 1'b0, vz, z, 8'd0});
  endtask

  task automatic drain(input string tag, input int n);
    logic [EW-1:0] e;
    for (int i = 0; i < n; i++) begin
      step();
      if (exp_q.size() == 0) chk({tag, "_underflow"}, 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk(tag, 32'(obs), 32'(e));
      end
    end
  endtask

  task automatic doReset();
    Rst = 1'b1; Us = 4'b0; Adub = 1'b0;
    step();
    step();
    chk("rst_out", 32'(obs), 32'd0);
    chk("rst_state", 32'(dbgState), 32'd0);
    chk("rst_ptr", 32'(dbgPtr), 32'd0);
    chk("rst_pend", 32'(dbgAdubPend), 32'd0);
    Rst = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    Rst = 1'b1; Us = 4'b0; Nv = 2'b11; Adub = 1'b0;

    // 1: single zone 2, full duration
    doReset();
    Us = 4'b0100;
    pushPhase(4'b0100, 1'b0, 1'b0, 2'd2, 10, 40);
    pushIdle(2'd2, 1'b0); pushIdle(2'd2, 1'b0);
    drain("s1", 39);
    Us = 4'b0;
    drain("s1", 3);
    chk("s1_ptr", 32'(dbgPtr), 32'd3);

    // 2: all zones dry, round robin 0,1,2,3,0
    doReset();
    Us = 4'b1111;
    for (int z = 0; z < 5; z++) begin
      pushPhase(4'b0001 << (z % 4), 1'b0, 1'b0, 2'(z % 4), 10, 40);
      pushIdle(2'(z % 4), 1'b0);
    end
    drain("s2", 4 * 41 + 39);
    Us = 4'b0;
    drain("s2", 2);
    chk("s2_ptr", 32'(dbgPtr), 32'd1);

    // 3: tank empties mid-irrigation, zone 1 restarts on refill
    doReset();
    Us = 4'b0010;
    pushPhase(4'b0010, 1'b0, 1'b0, 2'd1, 10, 18);
    drain("s3", 18);
    Nv = 2'b00;
    for (int i = 0; i < 3; i++) pushIdle(2'd1, 1'b1);
    drain("s3_empty", 3);
    chk("s3_ptr_kept", 32'(dbgPtr), 32'd0);
    Nv = 2'b01;
    pushPhase(4'b0010, 1'b0, 1'b0, 2'd1, 10, 40);
    pushIdle(2'd1, 1'b0);
    drain("s3_refill", 39);
    Us = 4'b0;
    drain("s3_refill", 2);
    chk("s3_ptr", 32'(dbgPtr), 32'd2);
    Nv = 2'b11;

    // 4: fertilise request during zone 1 irrigation
    doReset();
    Us = 4'b0010;
    pushPhase(4'b0010, 1'b0, 1'b0, 2'd1, 10, 40);
    pushPhase(4'b0010, 1'b1, 1'b0, 2'd1, 4, 16);
    pushPhase(4'b0010, 1'b0, 1'b1, 2'd1, 3, 12);
    pushIdle(2'd1, 1'b0);
    drain("s4", 5);
    Adub = 1'b1;
    drain("s4", 1);
    Adub = 1'b0;
    chk("s4_pend_set", 32'(dbgAdubPend), 32'd1);
    drain("s4", 34 + 8);
    Us = 4'b0;
    drain("s4", 8 + 12 + 1);
    chk("s4_pend_clr", 32'(dbgAdubPend), 32'd0);
    chk("s4_state", 32'(dbgState), 32'd0);
    chk("s4_ptr", 32'(dbgPtr), 32'd2);

    // 5: reset during ADUBA drops the pending request
    doReset();
    Us = 4'b0001; Adub = 1'b1;
    pushPhase(4'b0001, 1'b0, 1'b0, 2'd0, 10, 40);
    pushPhase(4'b0001, 1'b1, 1'b0, 2'd0, 4, 6);
    drain("s5", 1);
    Adub = 1'b0;
    drain("s5", 45);
    Rst = 1'b1;
    step();
    chk("s5_rst_out", 32'(obs), 32'd0);
    chk("s5_rst_pend", 32'(dbgAdubPend), 32'd0);
    Rst = 1'b0;
    pushPhase(4'b0001, 1'b0, 1'b0, 2'd0, 10, 40);
    pushIdle(2'd0, 1'b0); pushIdle(2'd0, 1'b0);
    drain("s5_after", 39);
    Us = 4'b0;
    drain("s5_after", 3);
    chk("s5_pend", 32'(dbgAdubPend), 32'd0);

    // 6: zone 0 soil turns wet at tick 3
    doReset();
    Us = 4'b0001;
`ifdef REGA_EARLY_STOP_EN
    pushPhase(4'b0001, 1'b0, 1'b0, 2'd0, 10, 12);
    pushIdle(2'd0, 1'b0); pushIdle(2'd0, 1'b0);
    drain("s6", 11);
    Us = 4'b0;
    drain("s6", 3);
`else
    pushPhase(4'b0001, 1'b0, 1'b0, 2'd0, 10, 40);
    pushIdle(2'd0, 1'b0);
    drain("s6", 11);
    Us = 4'b0;
    drain("s6", 30);
`endif
    chk("s6_ptr", 32'(dbgPtr), 32'd1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
